// File: rtl/l2tol1_responder.sv
// l2tol1_responder: queued L2 lookup model answering L1 requests with ack snacks and tracking sharers.
// Define L2RESP_EXCL_GRANT_EN to grant exclusive (ACK_E) on shared requests when no sharers exist.
`ifndef SC_CMD_REQ_S
`define SC_CMD_REQ_S 3'b001
`endif
`ifndef SC_CMD_REQ_M
`define SC_CMD_REQ_M 3'b010
`endif
`ifndef SC_SCMD_ACK_S
`define SC_SCMD_ACK_S 5'd1
`endif
`ifndef SC_SCMD_ACK_M
`define SC_SCMD_ACK_M 5'd2
`endif
`ifndef SC_SCMD_ACK_E
`define SC_SCMD_ACK_E 5'd3
`endif
module l2tol1_responder #(
  parameter int LATENCY     = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int SHARER_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   l1tol2_req_valid,
  output logic                   l1tol2_req_retry,
  input  logic [2:0]             l1tol2_req,
  input  logic                   l1tol2_disp_valid,
  input  logic [2:0]             l1tol2_disp,
  output logic                   l2tol1_snack_valid,
  output logic [4:0]             l2tol1_snack,
  output logic [SHARER_BITS-1:0] sharer_cnt,
  output logic                   bad_cmd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [3:0] lat_q, lat_d;
  logic [2:0] cmd_q, cmd_d, head;
  logic [SHARER_BITS-1:0] sharer_q, sharer_d;
  logic [4:0] snack_q, snack_d;
  logic bad_q, bad_d, vld_q, vld_d;
  logic full, empty, push, pop, head_ok, inc, excl, unused;
  assign unused = ^l1tol2_disp;
  // extra wrap bit tells full from empty when the indices match
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = wr_q == rd_q;
  assign push    = l1tol2_req_valid && !full;
  assign pop     = state_q == IDLE && !empty;
  assign head    = mem_q[rd_q[AW-1:0]];
  assign head_ok = head == `SC_CMD_REQ_S || head == `SC_CMD_REQ_M;
  assign inc     = state_q == RESP;
  always_comb begin
    state_d = state_q == IDLE ? (pop && head_ok ? WAIT : IDLE)
            : state_q == WAIT ? (lat_q == 4'd1 ? RESP : WAIT)
            : IDLE;
  end
  always_comb begin
    lat_d    = pop ? 4'(LATENCY) : state_q == WAIT ? lat_q - 4'd1 : lat_q;
    cmd_d    = pop ? head : cmd_q;
    bad_d    = bad_q | (pop & !head_ok);
    sharer_d = inc && !l1tol2_disp_valid && sharer_q != '1 ? sharer_q + SHARER_BITS'(1)
             : !inc && l1tol2_disp_valid && sharer_q != '0 ? sharer_q - SHARER_BITS'(1)
             : sharer_q;
`ifdef L2RESP_EXCL_GRANT_EN
    excl     = cmd_q == `SC_CMD_REQ_S && sharer_d == '0;
`else
    excl     = 1'b0;
`endif
    vld_d    = state_d == RESP;
    snack_d  = state_d != RESP ? 5'd0
             : excl ? `SC_SCMD_ACK_E
             : cmd_q == `SC_CMD_REQ_M ? `SC_SCMD_ACK_M : `SC_SCMD_ACK_S;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= l1tol2_req;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      lat_q    <= '0;
      cmd_q    <= '0;
      sharer_q <= '0;
      bad_q    <= 1'b0;
      vld_q    <= 1'b0;
      snack_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_q + {{AW{1'b0}}, push};
      rd_q     <= rd_q + {{AW{1'b0}}, pop};
      lat_q    <= lat_d;
      cmd_q    <= cmd_d;
      sharer_q <= sharer_d;
      bad_q    <= bad_d;
      vld_q    <= vld_d;
      snack_q  <= snack_d;
    end
  end
  assign l1tol2_req_retry   = full;
  assign l2tol1_snack_valid = vld_q;
  assign l2tol1_snack       = snack_q;
  assign sharer_cnt         = sharer_q;
  assign bad_cmd            = bad_q;
endmodule

// File: doc/l2tol1_responder.md
L2TOL1_RESPONDER -- requirements
Module: l2tol1_responder

Interface
REQ-001 Parameter LATENCY, default 3, SHALL set the L2 lookup delay in cycles (legal 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the request queue depth (power of 2, 2..16).
REQ-003 Parameter SHARER_BITS, default 4, SHALL set the width of the sharer counter.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; asserted when sampled low at a clk edge.
REQ-006 l1tol2_req_valid  input  1  L1 request valid.
REQ-007 l1tol2_req_retry  output  1  back-pressure to L1.
REQ-008 l1tol2_req  input  3  request command (`SC_CMD_REQ_S`, `SC_CMD_REQ_M` from scmemc.vh).
REQ-009 l1tol2_disp_valid  input  1  displacement valid; always accepted, no retry.
REQ-010 l1tol2_disp  input  3  displacement command (contents ignored).
REQ-011 l2tol1_snack_valid  output  1  response valid, one-cycle pulse.
REQ-012 l2tol1_snack  output  5  response command (`SC_SCMD_ACK_S`, `SC_SCMD_ACK_M`, `SC_SCMD_ACK_E`).
REQ-013 sharer_cnt  output  SHARER_BITS  current count of outstanding granted lines.
REQ-014 bad_cmd  output  1  sticky flag for an unrecognized request.

Function
REQ-015 A request SHALL be accepted on an edge where valid=1 and retry=0, and written into the FIFO at that edge.
REQ-016 l1tol2_req_retry SHALL equal the FIFO-full flag, derived combinationally from registered pointers.
REQ-017 When the FIFO is full, no push SHALL occur, even if a pop happens in the same cycle.
REQ-018 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra wrap bit to distinguish full from empty.
REQ-019 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-020 From IDLE with the FIFO non-empty, the FSM SHALL pop the head, load lat_cnt=LATENCY and go to WAIT.
REQ-021 In WAIT, lat_cnt SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where lat_cnt==1.
REQ-022 In RESP, snack_valid=1 SHALL be driven for exactly one cycle with the registered snack, then the FSM SHALL return to IDLE.
REQ-023 Latency: with the FSM idle and the FIFO empty, a request accepted at edge E0 SHALL produce snack_valid high in the cycle following edge E0+LATENCY+1.
REQ-024 Throughput SHALL be one response per LATENCY+2 cycles.
REQ-025 Responses SHALL be issued in FIFO (arrival) order.
REQ-026 `SC_CMD_REQ_S` SHALL be answered with `SC_SCMD_ACK_S`; `SC_CMD_REQ_M` SHALL be answered with `SC_SCMD_ACK_M` (subject to REQ-035).
REQ-027 Any other request value SHALL be popped and discarded with no response, and SHALL set bad_cmd=1 until reset.
REQ-028 sharer_cnt SHALL increment on every RESP cycle and decrement on every cycle with l1tol2_disp_valid=1.
REQ-029 When a RESP cycle and a displacement coincide, sharer_cnt SHALL be unchanged.
REQ-030 sharer_cnt SHALL saturate at 0 and at 2^SHARER_BITS-1, never wrapping.
REQ-031 When snack_valid=0, l2tol1_snack SHALL hold 0.

Reset
REQ-032 While reset=0 at an edge: the FIFO SHALL be emptied, FSM=IDLE, lat_cnt=0, sharer_cnt=0, bad_cmd=0, snack_valid=0, snack=0.
REQ-033 After reset, l1tol2_req_retry SHALL be 0.
REQ-034 A reset asserted mid-WAIT or mid-RESP SHALL abort the transaction, with no response issued afterward.

Configuration
REQ-035 With L2RESP_EXCL_GRANT_EN defined, `SC_CMD_REQ_S` SHALL be answered with `SC_SCMD_ACK_E` when sharer_cnt==0 at the RESP cycle, and with `SC_SCMD_ACK_S` otherwise.
REQ-036 Without L2RESP_EXCL_GRANT_EN defined, `SC_SCMD_ACK_E` SHALL never be issued.

Verification
REQ-037 Single `SC_CMD_REQ_S` at edge 10, LATENCY=3 -> one snack_valid pulse in the cycle after edge 14 carrying `SC_SCMD_ACK_S`, and sharer_cnt 0->1.
REQ-038 Five back-to-back `SC_CMD_REQ_M`, FIFO_DEPTH=4, starting at reset release -> retry asserted once the FIFO holds 4 entries; 5th request accepted after the first pop; 5 `SC_SCMD_ACK_M` pulses spaced 5 cycles apart, in order.
REQ-039 l1tol2_req=3'b111 -> no snack, bad_cmd=1 held; a following `SC_CMD_REQ_S` is still answered normally.
REQ-040 Displacement coincident with a RESP cycle at sharer_cnt=2 -> sharer_cnt stays 2; 3 displacements with sharer_cnt=1 -> 0, saturated.
REQ-041 reset=0 during WAIT with 2 entries queued -> no snack afterward, retry=0, sharer_cnt=0.
REQ-042 With L2RESP_EXCL_GRANT_EN: first `SC_CMD_REQ_S` -> `SC_SCMD_ACK_E`; second -> `SC_SCMD_ACK_S`.
